instr_fetch: RTL

Instruction fetch unit that owns the architectural fetch address and reads instruction memory on its behalf. It issues word requests to instruction memory over a valid/ready request channel, accepts in-order responses of arbitrary latency, buffers them with their PC in a DEPTH-entry FIFO, and presents them to decode over a valid/ready channel. A redirect input, driven by branch/jump resolution, reloads the fetch address and discards every stale instruction.

---
 rtl/instr_fetch.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Owns the architectural fetch address, issues word
// requests to instruction memory over a valid/ready channel, accepts in-order
// responses of any latency, buffers them together with their PC in a
// DEPTH-entry FIFO and presents them to decode over a valid/ready channel.
// A redirect reloads the fetch address, flushes the FIFO and marks every
// request still in flight as stale so its response is discarded on return.
//
// Parameters
//   RESET_PC  fetch address loaded on reset (word aligned)
//   DEPTH     FIFO entries and maximum in-flight requests (power of 2, >= 2)
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   redirect_valid, redirect_pc      branch/jump redirect
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_resp_valid/data             in-order response channel
//   inst_valid/ready, inst_data/pc   decode channel (FIFO head)
//   fetch_pc                         next address to request
//   misalign_err                     sticky: a redirect target was misaligned
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_pc,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);   // pointer width
    localparam int CW = AW + 1;          // counter width, holds 0..DEPTH

    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);

    // Circular pointer advance; DEPTH is a power of two so wrap is free.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1'b1);
    endfunction

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] fifo_count_r;
    logic [AW-1:0] tag_wr_r;
    logic [AW-1:0] tag_rd_r;
    logic [AW-1:0] fifo_wr_r;
    logic [AW-1:0] fifo_rd_r;
    logic [31:0]   tag_mem_r  [DEPTH];
    logic [31:0]   fifo_pc_r  [DEPTH];
    logic [31:0]   fifo_data_r[DEPTH];
    logic          misalign_r;

    logic [CW:0]   credit_used_s;
    logic          can_issue_s;
    logic          req_fire_s;
    logic          resp_fire_s;
    logic          push_s;
    logic          pop_s;

    // Credits cover both outstanding requests and buffered instructions, so a
    // returning response always finds a free FIFO slot.
    assign credit_used_s = {1'b0, inflight_r} + {1'b0, fifo_count_r};
    assign can_issue_s   = (credit_used_s < DEPTH_L);

    assign imem_req_valid = can_issue_s & ~redirect_valid & ~reset;
    assign imem_req_addr  = fetch_pc_r;
    assign req_fire_s     = imem_req_valid & imem_req_ready;

    // Responses with nothing outstanding belong to requests issued before a
    // reset and are ignored.
    assign resp_fire_s = imem_resp_valid & (inflight_r != ZERO_C);
    assign push_s      = resp_fire_s & ~redirect_valid & (drop_r == ZERO_C);

    assign inst_valid = (fifo_count_r != ZERO_C) & ~redirect_valid;
    assign pop_s      = inst_valid & inst_ready;
    assign inst_data  = fifo_data_r[fifo_rd_r];
    assign inst_pc    = fifo_pc_r[fifo_rd_r];

    assign fetch_pc     = fetch_pc_r;
    assign misalign_err = misalign_r;

    // Fetch address: reload on redirect, advance one word per accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Outstanding request counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_r <= ZERO_C;
        end else begin
            case ({req_fire_s, resp_fire_s})
                2'b10:   inflight_r <= inflight_r + ONE_C;
                2'b01:   inflight_r <= inflight_r - ONE_C;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Stale-response counter. A redirect marks everything still outstanding
    // after the edge as stale; a response in the redirect cycle itself is
    // already discarded and is therefore not counted. No request can be
    // accepted in a redirect cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r <= ZERO_C;
        end else if (redirect_valid) begin
            drop_r <= inflight_r - CW'(resp_fire_s);
        end else if (resp_fire_s && (drop_r != ZERO_C)) begin
            drop_r <= drop_r - ONE_C;
        end else begin
            drop_r <= drop_r;
        end
    end

    // PC tag queue: remembers the address of each outstanding request so the
    // in-order response can be paired with it. Not flushed on redirect since
    // stale responses still pop their tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_wr_r <= AW'(1'b0);
            tag_rd_r <= AW'(1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (req_fire_s) begin
                tag_mem_r[tag_wr_r] <= fetch_pc_r;
                tag_wr_r            <= ptr_inc(tag_wr_r);
            end else begin
                tag_wr_r <= tag_wr_r;
            end
            if (resp_fire_s) begin
                tag_rd_r <= ptr_inc(tag_rd_r);
            end else begin
                tag_rd_r <= tag_rd_r;
            end
        end
    end

    // Instruction FIFO; flushed on redirect. Registered only, no bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_r    <= AW'(1'b0);
            fifo_rd_r    <= AW'(1'b0);
            fifo_count_r <= ZERO_C;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_data_r[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            fifo_wr_r    <= AW'(1'b0);
            fifo_rd_r    <= AW'(1'b0);
            fifo_count_r <= ZERO_C;
        end else begin
            if (push_s) begin
                fifo_pc_r[fifo_wr_r]   <= tag_mem_r[tag_rd_r];
                fifo_data_r[fifo_wr_r] <= imem_resp_data;
                fifo_wr_r              <= ptr_inc(fifo_wr_r);
            end else begin
                fifo_wr_r <= fifo_wr_r;
            end
            if (pop_s) begin
                fifo_rd_r <= ptr_inc(fifo_rd_r);
            end else begin
                fifo_rd_r <= fifo_rd_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + ONE_C;
                2'b01:   fifo_count_r <= fifo_count_r - ONE_C;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

endmodule
